shift_pipe: RTL and testbench

//  Parametrised, pipelined ARM barrel shifter for operand-2 of the ARM data path; successor to the

---
 rtl/shift_pipe_pkg.sv | 36 +++
 rtl/shift_pipe_stage.sv | 46 ++++
 rtl/shift_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_shift_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared types and helpers for the pipelined ARM operand-2 barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic {
        AMT_IMM = 1'b0,
        AMT_REG = 1'b1
    } amt_src_e;

    typedef enum logic [2:0] {
        SC_NORMAL,
        SC_ZERO_FILL,
        SC_SIGN_FILL,
        SC_RRX,
        SC_PASS
    } special_e;

    function automatic int log2w(input int w);
        return $clog2(w);
    endfunction

    // Section that owns mux level lvl; section 0 is decode-only when stages > 1.
    function automatic int level_stage(input int lvl, input int log_w, input int stages);
        if (stages == 1) begin
            return 0;
        end
        return 1 + (lvl * (stages - 1)) / log_w;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One elastic pipeline slot: valid flag plus payload, advancing when downstream frees.
module shift_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_data_o
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;
    logic          advance;

    assign advance    = !valid_q || out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined ARM barrel shifter: decode special cases up front, then
// log2(WIDTH) shift levels spread over the remaining elastic stages.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_W  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [2:0]       SHIFT_OP,
    input  logic [WIDTH-1:0] Shift_Data,
    input  logic [NUM_W-1:0] Shift_Num,
    input  logic             Carry_flag,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Shift_Out,
    output logic             Shift_Carry_Out
);

    localparam int LOG = log2w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LOG-1:0]   amt;
        shift_op_e        op;
        logic             c;
    } beat_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             c;
    } res_t;

    function automatic logic [WIDTH-1:0] shift_lvl(
        input logic [WIDTH-1:0] d,
        input shift_op_e        op,
        input int               j
    );
        logic [WIDTH-1:0] r;
        int               sh;
        sh = 1 << j;
        unique case (op)
            OP_LSL:  r = d << sh;
            OP_LSR:  r = d >> sh;
            OP_ASR:  r = WIDTH'($signed(d) >>> sh);
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    shift_op_e      op;
    logic           reg_amt;
    logic [31:0]    n;
    logic [LOG-1:0] k, k_dn, k_lsl;
    logic           sign;
    special_e       sc;
    logic           c_dec;
    beat_t          dec;

    always_comb begin
        op      = shift_op_e'(SHIFT_OP[2:1]);
        reg_amt = (amt_src_e'(SHIFT_OP[0]) == AMT_REG);
        k       = Shift_Num[LOG-1:0];
        n       = reg_amt ? 32'(Shift_Num) : 32'(k);
        k_dn    = k - LOG'(1);
        k_lsl   = LOG'(0) - k;
        sign    = Shift_Data[WIDTH-1];
        sc      = SC_NORMAL;
        c_dec   = (op == OP_LSL) ? Shift_Data[k_lsl] : Shift_Data[k_dn];
        unique case (1'b1)
            (n == 32'd0): begin
                if (reg_amt) begin
                    sc    = SC_PASS;
                    c_dec = Carry_flag;
                end else begin
                    unique case (op)
                        OP_LSL: begin
                            sc    = SC_PASS;
                            c_dec = Carry_flag;
                        end
                        OP_LSR: begin
                            sc    = SC_ZERO_FILL;
                            c_dec = sign;
                        end
                        OP_ASR: begin
                            sc    = SC_SIGN_FILL;
                            c_dec = sign;
                        end
                        OP_ROR: begin
                            sc    = SC_RRX;
                            c_dec = Shift_Data[0];
                        end
                        default: ;
                    endcase
                end
            end
            (n >= 32'(WIDTH)): begin
                unique case (op)
                    OP_LSL: begin
                        sc    = SC_ZERO_FILL;
                        c_dec = (n == 32'(WIDTH)) & Shift_Data[0];
                    end
                    OP_LSR: begin
                        sc    = SC_ZERO_FILL;
                        c_dec = (n == 32'(WIDTH)) & sign;
                    end
                    OP_ASR: begin
                        sc    = SC_SIGN_FILL;
                        c_dec = sign;
                    end
                    OP_ROR: begin
                        // Rotations by a multiple of WIDTH leave data intact.
                        if (k == '0) begin
                            sc    = SC_PASS;
                            c_dec = sign;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase

        dec.op   = op;
        dec.c    = c_dec;
        dec.amt  = '0;
        dec.data = Shift_Data;
        unique case (sc)
            SC_NORMAL:    dec.amt  = k;
            SC_ZERO_FILL: dec.data = '0;
            SC_SIGN_FILL: dec.data = {WIDTH{sign}};
            SC_RRX:       dec.data = {Carry_flag, Shift_Data[WIDTH-1:1]};
            SC_PASS:      ;
            default:      ;
        endcase
    end

    logic  fin_rdy, fin_v, fin_vq;
    beat_t fin_in;
    res_t  fin_nx, fin_q;

    for (genvar s = 0; s < STAGES - 1; s++) begin : g_st
        beat_t d_in, d_nx, q;
        logic  v_in, v_q, rdy_in, rdy_out;

        if (s == 0) begin : g_head
            assign d_in     = dec;
            assign v_in     = In_Valid;
            assign In_Ready = rdy_in;
        end else begin : g_body
            assign d_in = g_st[s-1].q;
            assign v_in = g_st[s-1].v_q;
        end

        if (s == STAGES - 2) begin : g_tail
            assign rdy_out = fin_rdy;
        end else begin : g_fwd
            assign rdy_out = g_st[s+1].rdy_in;
        end

        always_comb begin
            d_nx = d_in;
            for (int j = 0; j < LOG; j++) begin
                if (level_stage(j, LOG, STAGES) == s && d_in.amt[j]) begin
                    d_nx.data = shift_lvl(d_nx.data, d_in.op, j);
                end
            end
        end

        shift_pipe_stage #(
            .PW($bits(beat_t))
        ) u_stage (
            .clk        (clk),
            .rst_n      (Rst_n),
            .in_valid_i (v_in),
            .in_ready_o (rdy_in),
            .in_data_i  (d_nx),
            .out_valid_o(v_q),
            .out_ready_i(rdy_out),
            .out_data_o (q)
        );
    end

    if (STAGES == 1) begin : g_single
        assign fin_in   = dec;
        assign fin_v    = In_Valid;
        assign In_Ready = fin_rdy;
    end else begin : g_multi
        assign fin_in = g_st[STAGES-2].q;
        assign fin_v  = g_st[STAGES-2].v_q;
    end

    always_comb begin
        fin_nx.data = fin_in.data;
        fin_nx.c    = fin_in.c;
        for (int j = 0; j < LOG; j++) begin
            if (level_stage(j, LOG, STAGES) == STAGES - 1 && fin_in.amt[j]) begin
                fin_nx.data = shift_lvl(fin_nx.data, fin_in.op, j);
            end
        end
    end

    shift_pipe_stage #(
        .PW($bits(res_t))
    ) u_last (
        .clk        (clk),
        .rst_n      (Rst_n),
        .in_valid_i (fin_v),
        .in_ready_o (fin_rdy),
        .in_data_i  (fin_nx),
        .out_valid_o(fin_vq),
        .out_ready_i(Out_Ready),
        .out_data_o (fin_q)
    );

    assign Out_Valid       = fin_vq;
    assign Shift_Out       = fin_q.data;
    assign Shift_Carry_Out = fin_q.c;

endmodule

// File: tb/tb_shift_pipe.sv
// Randomised and directed bench for shift_pipe against a bit-level ARM shifter model.
module tb_shift_pipe;

    localparam int W  = 32;
    localparam int NW = 8;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          Rst_n;
    logic          In_Valid;
    logic          In_Ready;
    logic [2:0]    SHIFT_OP;
    logic [W-1:0]  Shift_Data;
    logic [NW-1:0] Shift_Num;
    logic          Carry_flag;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [W-1:0]  Shift_Out;
    logic          Shift_Carry_Out;

    int vectors    = 0;
    int miscompares = 0;

    logic [W:0] exp_q[$];
    logic       held = 1'b0;
    logic [W:0] held_val;

    shift_pipe #(
        .WIDTH (W),
        .NUM_W (NW),
        .STAGES(ST)
    ) dut (
        .clk            (clk),
        .Rst_n          (Rst_n),
        .In_Valid       (In_Valid),
        .In_Ready       (In_Ready),
        .SHIFT_OP       (SHIFT_OP),
        .Shift_Data     (Shift_Data),
        .Shift_Num      (Shift_Num),
        .Carry_flag     (Carry_flag),
        .Out_Valid      (Out_Valid),
        .Out_Ready      (Out_Ready),
        .Shift_Out      (Shift_Out),
        .Shift_Carry_Out(Shift_Carry_Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result {carry, data} derived bit by bit from the ARM shifter rules.
    function automatic logic [W:0] model(input logic [2:0] op3, input logic [W-1:0] d,
                                         input logic [NW-1:0] num, input logic cf);
        int         n;
        logic [W-1:0] r;
        logic       c;
        logic       sg;
        sg = d[W-1];
        n  = op3[0] ? int'(num) : int'(num) % W;
        r  = '0;
        c  = 1'b0;
        if (n == 0 && !op3[0]) begin
            case (op3[2:1])
                2'd0: begin r = d;        c = cf;   end
                2'd1: begin r = '0;       c = sg;   end
                2'd2: begin r = {W{sg}};  c = sg;   end
                default: begin r = {cf, d[W-1:1]}; c = d[0]; end
            endcase
        end else if (n == 0) begin
            r = d;
            c = cf;
        end else begin
            for (int i = 0; i < W; i++) begin
                case (op3[2:1])
                    2'd0: r[i] = (i >= n) ? d[i-n] : 1'b0;
                    2'd1: r[i] = (i + n < W) ? d[i+n] : 1'b0;
                    2'd2: r[i] = (i + n < W) ? d[i+n] : sg;
                    default: r[i] = d[(i+n)%W];
                endcase
            end
            case (op3[2:1])
                2'd0: c = (n <= W) ? d[W-n] : 1'b0;
                2'd1: c = (n <= W) ? d[n-1] : 1'b0;
                2'd2: c = (n < W) ? d[n-1] : sg;
                default: c = r[W-1];
            endcase
        end
        return {c, r};
    endfunction

    always @(negedge clk) begin
        if (!Rst_n) begin
            exp_q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_stable", {Out_Valid, Shift_Carry_Out, Shift_Out}, {1'b1, held_val});
            end
            if (Out_Valid && Out_Ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL stale_beat: got Out_Valid=1, expected 0 (nothing in flight)");
                end else begin
                    chk("result", {Shift_Carry_Out, Shift_Out}, exp_q.pop_front());
                end
            end
            held     = Out_Valid && !Out_Ready;
            held_val = {Shift_Carry_Out, Shift_Out};
            if (In_Valid && In_Ready) begin
                exp_q.push_back(model(SHIFT_OP, Shift_Data, Shift_Num, Carry_flag));
            end
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        int r;
        SHIFT_OP   = 3'($urandom);
        Shift_Data = W'($urandom);
        Carry_flag = 1'($urandom);
        r = $urandom_range(0, 7);
        case (r)
            0: Shift_Num = 8'd0;
            1: Shift_Num = 8'd31;
            2: Shift_Num = 8'd32;
            3: Shift_Num = 8'd33;
            4: Shift_Num = 8'd64;
            default: Shift_Num = NW'($urandom);
        endcase
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [W-1:0] d,
                             input logic [NW-1:0] num, input logic cf);
        logic acc;
        SHIFT_OP   = op;
        Shift_Data = d;
        Shift_Num  = num;
        Carry_flag = cf;
        In_Valid   = 1'b1;
        acc        = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = In_Ready;
            next_edge();
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        In_Valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !Out_Valid;
            next_edge();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a, o, l, run, acc, seen;

        Rst_n      = 1'b0;
        In_Valid   = 1'b0;
        Out_Ready  = 1'b1;
        SHIFT_OP   = '0;
        Shift_Data = '0;
        Shift_Num  = '0;
        Carry_flag = 1'b0;
        repeat (2) next_edge();
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_shift_out", 64'(Shift_Out), 64'd0);
        chk("rst_carry", 64'(Shift_Carry_Out), 64'd0);
        chk("rst_in_ready", 64'(In_Ready), 64'd1);
        Rst_n = 1'b1;
        next_edge();

        chk("lit_lsl4", 64'(model(3'b000, 32'hAAAAFF00, 8'h04, 1'b0)), {31'd0, 1'b0, 32'hAAAFF000});
        chk("lit_lsr32", 64'(model(3'b010, 32'hAAAAFF00, 8'h00, 1'b0)), {31'd0, 1'b1, 32'h00000000});
        chk("lit_rrx", 64'(model(3'b110, 32'hAAAAFF00, 8'h00, 1'b1)), {31'd0, 1'b0, 32'hD5557F80});
        chk("lit_ror16", 64'(model(3'b111, 32'hAAAAFF00, 8'h10, 1'b0)), {31'd0, 1'b1, 32'hFF00AAAA});
        chk("lit_asr64", 64'(model(3'b101, 32'hAAAAFF00, 8'h40, 1'b0)), {31'd0, 1'b1, 32'hFFFFFFFF});
        chk("lit_lsr_r32", 64'(model(3'b011, 32'hAAAAFF00, 8'h20, 1'b0)), {31'd0, 1'b1, 32'h00000000});
        chk("lit_lsl_r64", 64'(model(3'b001, 32'hAAAAFF00, 8'h40, 1'b0)), {31'd0, 1'b0, 32'h00000000});
        chk("lit_lsl_r0", 64'(model(3'b001, 32'hAAAAFF00, 8'h00, 1'b1)), {31'd0, 1'b1, 32'hAAAAFF00});

        send_beat(3'b000, 32'hAAAAFF00, 8'h04, 1'b0);
        send_beat(3'b010, 32'hAAAAFF00, 8'h00, 1'b0);
        send_beat(3'b110, 32'hAAAAFF00, 8'h00, 1'b1);
        send_beat(3'b111, 32'hAAAAFF00, 8'h10, 1'b0);
        send_beat(3'b101, 32'hAAAAFF00, 8'h40, 1'b0);
        send_beat(3'b011, 32'hAAAAFF00, 8'h20, 1'b0);
        send_beat(3'b001, 32'hAAAAFF00, 8'h40, 1'b0);
        send_beat(3'b001, 32'hAAAAFF00, 8'h00, 1'b1);
        drain();

        // Streaming: six back-to-back beats with the consumer always ready.
        a = -1; o = -1; l = -1; run = 0;
        for (int i = 0; i < 6 + ST + 4; i++) begin
            if (i < 6) begin
                In_Valid = 1'b1;
                rand_fields();
            end else begin
                In_Valid = 1'b0;
            end
            @(negedge clk);
            if (In_Valid && In_Ready && a < 0) a = i;
            if (Out_Valid) begin
                if (o < 0) o = i;
                l = i;
                run++;
            end
            next_edge();
        end
        chk("stream_latency", 64'(o - a), 64'(ST));
        chk("stream_count", 64'(run), 64'd6);
        chk("stream_contig", 64'(l - o), 64'd5);
        drain();

        // Back-pressure: consumer stalls for the first three cycles of a 4-beat burst.
        acc = 0;
        rand_fields();
        for (int c = 0; c < 40 && acc < 4; c++) begin
            Out_Ready = (c >= 3);
            In_Valid  = 1'b1;
            @(negedge clk);
            if (c == ST) begin
                chk("bp_accepted", 64'(acc), 64'(ST));
                chk("bp_in_ready", 64'(In_Ready), 64'd0);
            end
            if (In_Ready) begin
                acc++;
            end
            next_edge();
            if (In_Ready || acc > 0) rand_fields();
        end
        chk("bp_all_sent", 64'(acc), 64'd4);
        drain();

        // Reset with two beats stuck in the pipe.
        Out_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            In_Valid = 1'b1;
            rand_fields();
            next_edge();
        end
        In_Valid = 1'b0;
        Rst_n    = 1'b0;
        next_edge();
        Rst_n = 1'b1;
        chk("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("mid_rst_shift_out", 64'(Shift_Out), 64'd0);
        chk("mid_rst_in_ready", 64'(In_Ready), 64'd1);
        Out_Ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (Out_Valid) seen++;
            next_edge();
        end
        chk("mid_rst_no_stale", 64'(seen), 64'd0);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 10000; i++) begin
            Out_Ready = ($urandom_range(0, 3) != 0);
            In_Valid  = ($urandom_range(0, 9) < 7);
            rand_fields();
            next_edge();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
